// File: rtl/cv32e40p_x_disp_mt.sv
// Multi-outstanding CORE-V-XIF dispatcher: ID-tagged offload table, per-register pending-write scoreboard.
// Define CV32E40P_X_DISP_MEM_ORDER_EN to hold internal loads/stores while offloaded memory ops are pending.
module cv32e40p_x_disp_mt #(
   parameter int unsigned X_ID_WIDTH      = 4,
   parameter int unsigned X_NUM_RS        = 3,
   parameter int unsigned MAX_OUTSTANDING = 4,
   parameter int unsigned SB_CNT_WIDTH    = 2
) (
   input  logic                                   clk_i,
   input  logic                                   rst_ni,
   input  logic                                   x_illegal_insn_dec_i,
   input  logic                                   x_branch_or_jump_i,
   input  logic                                   id_ready_i,
   input  logic [X_NUM_RS-1:0][4:0]               x_rs_addr_i,
   input  logic [X_NUM_RS-1:0]                    x_regs_used_i,
   input  logic [4:0]                             x_waddr_id_i,
   input  logic [4:0]                             regfile_waddr_ex_i,
   input  logic                                   regfile_we_ex_i,
   input  logic                                   x_data_req_dec_i,
   output logic                                   x_issue_valid_o,
   input  logic                                   x_issue_ready_i,
   input  logic                                   x_issue_resp_accept_i,
   input  logic                                   x_issue_resp_writeback_i,
   input  logic                                   x_issue_resp_loadstore_i,
   output logic [X_ID_WIDTH-1:0]                  x_issue_req_id_o,
   output logic [X_NUM_RS-1:0]                    x_issue_req_rs_valid_o,
   output logic                                   x_commit_valid_o,
   output logic [X_ID_WIDTH-1:0]                  x_commit_id_o,
   output logic                                   x_commit_kill_o,
   input  logic                                   x_result_valid_i,
   input  logic                                   x_result_we_i,
   input  logic [X_ID_WIDTH-1:0]                  x_result_id_i,
   input  logic [4:0]                             x_result_rd_i,
   output logic                                   x_result_ready_o,
   output logic                                   x_stall_o,
   output logic                                   x_illegal_insn_o,
   output logic                                   x_protocol_err_o,
   output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   x_outstanding_o
);

   localparam int unsigned IDX_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
   localparam int unsigned OUT_W = $clog2(MAX_OUTSTANDING + 1);

   typedef logic [SB_CNT_WIDTH-1:0] cnt_t;

   typedef struct packed {
      logic                  valid;
      logic [X_ID_WIDTH-1:0] id;
      logic [4:0]            rd;
      logic                  writeback;
      logic                  loadstore;
   } entry_t;

   entry_t [MAX_OUTSTANDING-1:0] tbl_q, tbl_d;
   cnt_t   [31:0]                sb_q, sb_d;
   logic   [X_ID_WIDTH-1:0]      id_q, id_d;
   logic                         offloaded_q, offloaded_d;
   logic                         commit_valid_q;
   logic   [X_ID_WIDTH-1:0]      commit_id_q;
   logic                         commit_kill_q;
   logic                         perr_q, perr_d;

   logic             full;
   logic             id_busy;
   logic             res_hit;
   logic             ls_pending;
   logic [IDX_W-1:0] free_idx;
   logic [IDX_W-1:0] res_idx;
   logic [OUT_W-1:0] outstanding;
   logic             sb_sat;
   logic             handshake;
   logic             alloc;
   logic             res_fire;
   logic             sb_inc;
   logic             sb_dec;
   logic             sb_underflow;
   logic             dep_any;
   logic             memstall;
   logic             unused_entry_bits;

   // Table scan on registered state only: a freed entry becomes usable one cycle later.
   // NOTE: every variable written in an always_comb gets a default first, otherwise a latch is inferred.
   always_comb begin
      full              = 1'b1;
      id_busy           = 1'b0;
      res_hit           = 1'b0;
      ls_pending        = 1'b0;
      free_idx          = '0;
      res_idx           = '0;
      outstanding       = '0;
      unused_entry_bits = 1'b0;
      for (int i = int'(MAX_OUTSTANDING) - 1; i >= 0; i--) begin
         unused_entry_bits = unused_entry_bits ^ (^{tbl_q[i].rd, tbl_q[i].writeback});
         if (!tbl_q[i].valid) begin
            full     = 1'b0;
            free_idx = IDX_W'(i);
         end else begin
            outstanding = outstanding + OUT_W'(1);
            if (tbl_q[i].id == id_q) id_busy = 1'b1;
            if (tbl_q[i].loadstore) ls_pending = 1'b1;
            if (tbl_q[i].id == x_result_id_i) begin
               res_hit = 1'b1;
               res_idx = IDX_W'(i);
            end
         end
      end
   end

`ifdef CV32E40P_X_DISP_MEM_ORDER_EN
   assign memstall = x_data_req_dec_i & ls_pending;
`else
   logic unused_memord;
   assign memstall      = 1'b0;
   assign unused_memord = x_data_req_dec_i ^ ls_pending;
`endif

   assign sb_sat = (sb_q[x_waddr_id_i] == '1);

   assign x_issue_valid_o = x_illegal_insn_dec_i & ~x_branch_or_jump_i & ~offloaded_q &
                            ~full & ~id_busy & ~sb_sat;
   assign handshake       = x_issue_valid_o & x_issue_ready_i;
   assign alloc           = handshake & x_issue_resp_accept_i;
   assign res_fire        = x_result_valid_i & res_hit;

   always_comb begin
      x_issue_req_rs_valid_o = '0;
      dep_any                = 1'b0;
      for (int i = 0; i < int'(X_NUM_RS); i++) begin
         x_issue_req_rs_valid_o[i] = ((sb_q[x_rs_addr_i[i]] == '0) || (x_rs_addr_i[i] == 5'd0)) &&
                                     !(regfile_we_ex_i && (x_rs_addr_i[i] == regfile_waddr_ex_i));
         if (x_regs_used_i[i] && (sb_q[x_rs_addr_i[i]] != '0)) dep_any = 1'b1;
      end
   end

   always_comb begin
      tbl_d = tbl_q;
      if (res_fire) tbl_d[res_idx].valid = 1'b0;
      if (alloc) begin
         tbl_d[free_idx].valid     = 1'b1;
         tbl_d[free_idx].id        = id_q;
         tbl_d[free_idx].rd        = x_waddr_id_i;
         tbl_d[free_idx].writeback = x_issue_resp_writeback_i;
         tbl_d[free_idx].loadstore = x_issue_resp_loadstore_i;
      end
   end

   assign sb_inc = alloc & x_issue_resp_writeback_i & (x_waddr_id_i != 5'd0);
   assign sb_dec = res_fire & x_result_we_i & (x_result_rd_i != 5'd0);

   // Simultaneous +1/-1 on the same register nets to zero and is not an underflow.
   always_comb begin
      sb_d         = sb_q;
      sb_underflow = 1'b0;
      if (!(sb_inc && sb_dec && (x_waddr_id_i == x_result_rd_i))) begin
         if (sb_inc) sb_d[x_waddr_id_i] = sb_q[x_waddr_id_i] + cnt_t'(1);
         if (sb_dec) begin
            if (sb_q[x_result_rd_i] == '0) sb_underflow = 1'b1;
            else                           sb_d[x_result_rd_i] = sb_q[x_result_rd_i] - cnt_t'(1);
         end
      end
   end

   assign perr_d      = perr_q | (x_result_valid_i & ~res_hit) | sb_underflow;
   assign id_d        = handshake ? id_q + X_ID_WIDTH'(1) : id_q;
   assign offloaded_d = id_ready_i ? 1'b0 : (offloaded_q | handshake);

   // NOTE: sequential state uses non-blocking assignments only; the table and scoreboard
   // are reset in full because valid bits and counters must be known from the first cycle.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         tbl_q          <= '0;
         sb_q           <= '0;
         id_q           <= '0;
         offloaded_q    <= 1'b0;
         commit_valid_q <= 1'b0;
         commit_id_q    <= '0;
         commit_kill_q  <= 1'b0;
         perr_q         <= 1'b0;
      end else begin
         tbl_q          <= tbl_d;
         sb_q           <= sb_d;
         id_q           <= id_d;
         offloaded_q    <= offloaded_d;
         commit_valid_q <= handshake;
         perr_q         <= perr_d;
         if (handshake) begin
            commit_id_q   <= id_q;
            commit_kill_q <= ~x_issue_resp_accept_i;
         end
      end
   end

   assign x_issue_req_id_o = id_q;
   assign x_commit_valid_o = commit_valid_q;
   assign x_commit_id_o    = commit_id_q;
   assign x_commit_kill_o  = commit_kill_q;
   assign x_result_ready_o = 1'b1;
   assign x_illegal_insn_o = handshake & ~x_issue_resp_accept_i;
   assign x_protocol_err_o = perr_q;
   assign x_outstanding_o  = outstanding;

   assign x_stall_o = (x_issue_valid_o & ~x_issue_ready_i) |
                      (~x_illegal_insn_dec_i & dep_any) |
                      (x_illegal_insn_dec_i & (x_branch_or_jump_i | full | id_busy | sb_sat)) |
                      memstall;

endmodule
